// File: rtl/grayscale_frame_ctrl_if.sv
// grayscale_frame_ctrl_if
//   Handshake bundle between the input FIFO, the frame controller and the
//   grayscale core, plus the per-pixel position tags issued with each read.
//   master : frame controller side (drives up_rd_en, dn_empty, pix_*)
//   slave  : FIFO/core side (drives up_empty, dn_rd_en, core_wr_en)
//   Signals:
//     up_empty   FIFO empty flag          up_rd_en   FIFO read enable
//     dn_empty   gated empty to core      dn_rd_en   core read request
//     core_wr_en core result write (monitored only)
//     pix_col/pix_row  position of the next pixel to issue
//     pix_sof/eol/eof  tags of the issued pixel, qualified by up_rd_en
interface grayscale_frame_ctrl_if #(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540
);
  localparam int COLW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROWW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic            up_empty;
  logic            up_rd_en;
  logic            dn_empty;
  logic            dn_rd_en;
  logic            core_wr_en;
  logic [COLW-1:0] pix_col;
  logic [ROWW-1:0] pix_row;
  logic            pix_sof;
  logic            pix_eol;
  logic            pix_eof;

  modport master (
    input  up_empty, dn_rd_en, core_wr_en,
    output up_rd_en, dn_empty, pix_col, pix_row, pix_sof, pix_eol, pix_eof
  );

  modport slave (
    output up_empty, dn_rd_en, core_wr_en,
    input  up_rd_en, dn_empty, pix_col, pix_row, pix_sof, pix_eol, pix_eof
  );
endinterface

// File: rtl/grayscale_frame_ctrl.sv
// grayscale_frame_ctrl
//   Frame sequencer between the 24-bit input FIFO and the grayscale core.
//   Each accepted start releases exactly WIDTH*HEIGHT FIFO reads, then waits
//   for the same number of core result writes before pulsing frame_done.
//   Ports:
//     clock, reset   system clock, synchronous active-high reset
//     start          single-cycle frame start (honoured only when idle)
//     io             FIFO/core handshake bundle (master modport)
//     frame_busy     high from the cycle after start through DONE
//     frame_done     one-cycle pulse after the last result write
//     frame_count    completed frames since reset (wraps)
//     err_spurious   sticky: core write while idle or beyond frame size
//     wdog_abort     (GS_FRAME_WATCHDOG_EN only) sticky stall abort flag
//   Optional feature: define GS_FRAME_WATCHDOG_EN to add the stall watchdog
//   (parameter WDOG_CYCLES, output wdog_abort).
module grayscale_frame_ctrl #(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540
`ifdef GS_FRAME_WATCHDOG_EN
  ,
  parameter int WDOG_CYCLES = 4096
`endif
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  grayscale_frame_ctrl_if.master io,
  output logic                   frame_busy,
  output logic                   frame_done,
  output logic [15:0]            frame_count,
`ifdef GS_FRAME_WATCHDOG_EN
  output logic                   wdog_abort,
`endif
  output logic                   err_spurious
);
  localparam int CW    = $clog2(WIDTH*HEIGHT+1);
  localparam int COLW  = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROWW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0]   TOTAL    = CW'(WIDTH*HEIGHT);
  localparam logic [COLW-1:0] COL_LAST = COLW'(WIDTH-1);
  localparam logic [ROWW-1:0] ROW_LAST = ROWW'(HEIGHT-1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   in_cnt_q, in_cnt_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic [COLW-1:0] col_q, col_d;
  logic [ROWW-1:0] row_q, row_d;
  logic [15:0]     count_q, count_d;
  logic            err_q, err_d;
  logic            dn_empty, up_rd_en;
`ifdef GS_FRAME_WATCHDOG_EN
  logic [15:0]     wdog_cnt_q, wdog_cnt_d;
  logic            wdog_q, wdog_d;
`endif

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    col_d     = col_q;
    row_d     = row_q;
    count_d   = count_q;
    err_d     = err_q;
    dn_empty  = 1'b1;
    up_rd_en  = 1'b0;
`ifdef GS_FRAME_WATCHDOG_EN
    wdog_cnt_d = wdog_cnt_q;
    wdog_d     = wdog_q;
`endif

    // Result counter runs in RUN and DRAIN; a write beyond the frame size
    // cannot belong to this frame, so it is flagged instead of counted.
    if ((state_q == RUN || state_q == DRAIN) && io.core_wr_en) begin
      if (out_cnt_q == TOTAL) err_d = 1'b1;
      else                    out_cnt_d = out_cnt_q + CW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          col_d     = '0;
          row_d     = '0;
          err_d     = 1'b0;
`ifdef GS_FRAME_WATCHDOG_EN
          wdog_cnt_d = '0;
          wdog_d     = 1'b0;
`endif
        end
        // Checked after the start clear so a coincident stray write is kept.
        if (io.core_wr_en) err_d = 1'b1;
      end
      RUN: begin
        dn_empty = io.up_empty | (in_cnt_q == TOTAL);
        up_rd_en = io.dn_rd_en & ~dn_empty;
        if (up_rd_en) begin
          in_cnt_d = in_cnt_q + CW'(1);
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + ROWW'(1);
          end else begin
            col_d = col_q + COLW'(1);
          end
          if (in_cnt_q == TOTAL - CW'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Uses the updated count so the final write exits without a bubble.
        if (out_cnt_d == TOTAL) state_d = DONE;
      end
      DONE: begin
        count_d = count_q + 16'd1;
        state_d = IDLE;
        if (io.core_wr_en) err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

`ifdef GS_FRAME_WATCHDOG_EN
    if (state_q == RUN || state_q == DRAIN) begin
      wdog_cnt_d = (up_rd_en | io.core_wr_en) ? '0 : wdog_cnt_q + 16'd1;
      if (wdog_cnt_d == 16'(WDOG_CYCLES)) begin
        wdog_d  = 1'b1;
        state_d = IDLE;
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
`ifdef GS_FRAME_WATCHDOG_EN
      wdog_cnt_q <= '0;
      wdog_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      count_q   <= count_d;
      err_q     <= err_d;
`ifdef GS_FRAME_WATCHDOG_EN
      wdog_cnt_q <= wdog_cnt_d;
      wdog_q     <= wdog_d;
`endif
    end
  end

  assign io.dn_empty  = dn_empty;
  assign io.up_rd_en  = up_rd_en;
  assign io.pix_col   = col_q;
  assign io.pix_row   = row_q;
  assign io.pix_sof   = up_rd_en & (col_q == '0) & (row_q == '0);
  assign io.pix_eol   = up_rd_en & (col_q == COL_LAST);
  assign io.pix_eof   = up_rd_en & (in_cnt_q == TOTAL - CW'(1));
  assign frame_busy   = (state_q != IDLE);
  assign frame_done   = (state_q == DONE);
  assign frame_count  = count_q;
  assign err_spurious = err_q;
`ifdef GS_FRAME_WATCHDOG_EN
  assign wdog_abort   = wdog_q;
`endif
endmodule

// File: doc/grayscale_frame_ctrl.md
Name: grayscale_frame_ctrl

Overview:
Frame sequencer between the 24-bit input FIFO and the grayscale core. It gates the FIFO read handshake so exactly one WIDTH x HEIGHT frame is released per start command. It tracks pixel column/row and counts 8-bit results written by the core. It reports frame busy/done status and a completed-frame count to the host.

Parameters:
WIDTH, 720, pixels per line (>=1)
HEIGHT, 540, lines per frame (>=1)
CW, $clog2(WIDTH*HEIGHT+1), pixel counter width (derived localparam, not overridable)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle frame start request
up_empty  in  1  empty flag from input FIFO
up_rd_en  out  1  read enable to input FIFO
dn_empty  out  1  gated empty flag presented to grayscale core in_empty
dn_rd_en  in  1  read request from grayscale core in_rd_en
core_wr_en  in  1  core out_wr_en, monitored only
frame_busy  out  1  high from accept of start until frame_done
frame_done  out  1  one-cycle pulse when last result written
pix_col  out  $clog2(WIDTH)  column of next pixel to issue
pix_row  out  $clog2(HEIGHT)  row of next pixel to issue
pix_sof  out  1  issued pixel is (0,0), qualified by up_rd_en
pix_eol  out  1  issued pixel has col WIDTH-1, qualified by up_rd_en
pix_eof  out  1  issued pixel is last of frame, qualified by up_rd_en
frame_count  out  16  frames completed since reset, wraps 0xFFFF->0
err_spurious  out  1  sticky: core_wr_en seen while not busy

Behaviour:
- One clock domain. Reset is synchronous and active-high. All state updates on rising clock.
- Reset values: state IDLE, in_cnt=out_cnt=0, pix_col=pix_row=0, frame_busy=0, frame_done=0, frame_count=0, err_spurious=0. dn_empty=1 and up_rd_en=0 while in IDLE.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 -> RUN next cycle. Clear in_cnt, out_cnt, pix_col, pix_row and err_spurious.
  - frame_busy rises the cycle after start.
- RUN:
  - dn_empty = up_empty | (in_cnt==TOTAL), where TOTAL=WIDTH*HEIGHT.
  - up_rd_en = dn_rd_en & ~dn_empty. Combinational, zero added latency.
  - Each issue increments in_cnt and advances pix_col; pix_col wraps WIDTH-1->0 with pix_row+1.
  - Issue of pixel TOTAL-1 -> DRAIN next cycle.
- DRAIN:
  - dn_empty=1, up_rd_en=0.
  - Wait for out_cnt==TOTAL, including the increment in the current cycle, then -> DONE.
- out_cnt increments on core_wr_en in RUN and DRAIN. It saturates at TOTAL; an extra write sets err_spurious.
- DONE:
  - Lasts one cycle with frame_done=1 and frame_busy=1.
  - frame_count+1. Next state IDLE.
- start in RUN, DRAIN or DONE is ignored (no queueing). start in the IDLE cycle right after DONE is accepted.
- core_wr_en in IDLE sets err_spurious; out_cnt is unchanged.
- Simultaneous final issue and a core write in RUN: both counters update in the same cycle.
- up_empty=1 in RUN stalls the frame with no timeout; counters hold.
- Reset mid-frame: immediate return to IDLE and all counters cleared. FIFO contents are not flushed; upstream must reset the FIFOs in the same cycle.
- pix_sof/eol/eof are 0 whenever up_rd_en=0.

Optional Feature:
Macro GS_FRAME_WATCHDOG_EN.
- Defined:
  - Adds parameter WDOG_CYCLES (default 4096) and output port wdog_abort (1-bit, sticky until next start or reset).
  - A 16-bit idle counter runs in RUN and DRAIN. It clears on any up_rd_en or core_wr_en.
  - When the counter reaches WDOG_CYCLES: set wdog_abort and go to IDLE without a frame_done pulse; frame_count unchanged.
- Undefined: no watchdog logic, no wdog_abort port, frames may stall indefinitely.

Test Plan:
All scenarios use WIDTH=4, HEIGHT=2 (TOTAL=8).
1. Reset, FIFO preloaded with 8 pixels, start pulse, core reads continuously, result written 1 cycle after each read -> up_rd_en high for 8 cycles; pix_sof on read 1, pix_eol on reads 4 and 8, pix_eof on read 8; frame_done pulses once after 8th write; frame_count=1.
2. FIFO holds 12 pixels, one frame -> exactly 8 up_rd_en pulses; dn_empty=1 after the 8th despite up_empty=0; 4 pixels remain.
3. up_empty toggled every other cycle during RUN -> in_cnt, pix_col and pix_row hold while empty; frame still completes with frame_done and frame_count=1.
4. start pulsed again mid-RUN and during DRAIN -> ignored; frame_count increments by exactly 1; back-to-back start in the IDLE cycle after DONE starts frame 2.
5. core_wr_en pulsed in IDLE -> err_spurious=1 and stays set; next start clears it.
6. Reset asserted after 5 reads -> next cycle frame_busy=0, pix_col=0, pix_row=0, frame_count unchanged from pre-frame value (0 after reset); with GS_FRAME_WATCHDOG_EN and WDOG_CYCLES=16, a stall of 16 cycles in RUN -> wdog_abort=1, IDLE, no frame_done.
